// File: rtl/pe_vinsn_queue.sv
// rtl/pe_vinsn_queue.sv - per-PE vector instruction request queue with duplicate suppression and hazard retirement (optional same-cycle bypass: PE_VINSN_QUEUE_BYPASS_EN)

package pe_pkg;
    localparam int unsigned PkgNrVInsn = 8;

    typedef logic [$clog2(PkgNrVInsn)-1:0] vid_t;

    typedef enum logic [2:0] {
        VFU_Alu       = 3'd0,
        VFU_MFpu      = 3'd1,
        VFU_SlideUnit = 3'd2,
        VFU_MaskUnit  = 3'd3,
        VFU_LoadUnit  = 3'd4,
        VFU_StoreUnit = 3'd5,
        VFU_None      = 3'd6
    } vfu_e;

    typedef struct packed {
        vid_t                  id;
        vfu_e                  vfu;
        logic [7:0]            op;
        logic [PkgNrVInsn-1:0] hazard_vs1;
        logic [PkgNrVInsn-1:0] hazard_vs2;
        logic [PkgNrVInsn-1:0] hazard_vd;
        logic [PkgNrVInsn-1:0] hazard_vm;
        logic [PkgNrVInsn-1:0] vinsn_running;
    } pe_req_t;

    typedef struct packed {
        logic [PkgNrVInsn-1:0] vinsn_done;
    } pe_resp_t;
endpackage

module pe_vinsn_queue
    import pe_pkg::*;
#(
    parameter int unsigned NrVInsn       = PkgNrVInsn,
    parameter int unsigned QueueDepth    = 4,
    parameter logic [7:0]  AcceptVfuMask = 8'b11
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  pe_req_t  pe_req_i,
    input  logic     pe_req_valid_i,
    output logic     pe_req_ready_o,
    output pe_resp_t pe_resp_o,
    output pe_req_t  vinsn_o,
    output logic     vinsn_valid_o,
    output logic     vinsn_hazard_free_o,
    input  logic     vinsn_commit_i
);

    localparam int unsigned PtrW = $clog2(QueueDepth);

    // The bitmap widths are fixed by the shared request/response types.
    if (NrVInsn != PkgNrVInsn) begin : g_bad_nrvinsn
        $error("NrVInsn must match pe_pkg::PkgNrVInsn");
    end
    if (QueueDepth < 2 || (QueueDepth & (QueueDepth - 1)) != 0) begin : g_bad_depth
        $error("QueueDepth must be a power of two and at least 2");
    end

    pe_req_t            mem [QueueDepth];
    logic [PtrW-1:0]    rd_ptr, wr_ptr;
    logic [PtrW:0]      cnt;
    logic               acc_flag_q;
    vid_t               acc_id_q;
    logic [NrVInsn-1:0] done_q;

    logic    full, empty, relevant, dup, accept, push, pop, pop_stored, write;
    pe_req_t incoming;

    assign full     = (cnt == (PtrW+1)'(QueueDepth));
    assign empty    = (cnt == '0);
    assign relevant = AcceptVfuMask[pe_req_i.vfu];
    assign dup      = acc_flag_q && (acc_id_q == pe_req_i.id);
    // Handshake completes for irrelevant requests too; they are simply not stored.
    assign accept   = pe_req_valid_i && !full && !dup;
    assign push     = accept && relevant;

    assign pe_req_ready_o       = !full;
    assign pe_resp_o.vinsn_done = done_q;

    // Incoming request with hazards already cleared by this cycle's running vector.
    always_comb begin
        incoming            = pe_req_i;
        incoming.hazard_vs1 = pe_req_i.hazard_vs1 & pe_req_i.vinsn_running;
        incoming.hazard_vs2 = pe_req_i.hazard_vs2 & pe_req_i.vinsn_running;
        incoming.hazard_vd  = pe_req_i.hazard_vd  & pe_req_i.vinsn_running;
        incoming.hazard_vm  = pe_req_i.hazard_vm  & pe_req_i.vinsn_running;
    end

    // Head presentation; with bypass an empty queue forwards the pushing request.
    always_comb begin
        vinsn_o       = empty ? '0 : mem[rd_ptr];
        vinsn_valid_o = !empty;
`ifdef PE_VINSN_QUEUE_BYPASS_EN
        if (empty && push) begin
            vinsn_o       = incoming;
            vinsn_valid_o = 1'b1;
        end
`endif
    end

    assign vinsn_hazard_free_o = ~|{vinsn_o.hazard_vs1, vinsn_o.hazard_vs2,
                                    vinsn_o.hazard_vd, vinsn_o.hazard_vm};

    assign pop        = vinsn_commit_i && vinsn_valid_o;
    assign pop_stored = pop && !empty;
`ifdef PE_VINSN_QUEUE_BYPASS_EN
    // A bypassed request committed in the same cycle never touches storage.
    assign write      = push && !(empty && pop);
`else
    assign write      = push;
`endif

    // Entry storage: retire hazards on every entry, then write the pushed request.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < QueueDepth; i++) begin
            mem[i].hazard_vs1 <= mem[i].hazard_vs1 & pe_req_i.vinsn_running;
            mem[i].hazard_vs2 <= mem[i].hazard_vs2 & pe_req_i.vinsn_running;
            mem[i].hazard_vd  <= mem[i].hazard_vd  & pe_req_i.vinsn_running;
            mem[i].hazard_vm  <= mem[i].hazard_vm  & pe_req_i.vinsn_running;
        end
        if (write) begin
            mem[wr_ptr] <= incoming;
        end
    end

    // Pointers, occupancy, duplicate tracking and the registered done pulse.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            cnt        <= '0;
            acc_flag_q <= 1'b0;
            acc_id_q   <= '0;
            done_q     <= '0;
        end else begin
            if (write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_stored) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({write, pop_stored})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (!pe_req_valid_i) begin
                acc_flag_q <= 1'b0;
            end else if (accept) begin
                acc_flag_q <= 1'b1;
                acc_id_q   <= pe_req_i.id;
            end
            done_q <= pop ? (NrVInsn'(1) << vinsn_o.id) : '0;
        end
    end

endmodule

// File: tb/tb_pe_vinsn_queue.sv
// tb/tb_pe_vinsn_queue.sv - self-checking bench for pe_vinsn_queue

module tb_pe_vinsn_queue;
    import pe_pkg::*;

    localparam int DEPTH = 4;

    logic     clk = 1'b0;
    logic     rst_n;
    pe_req_t  req;
    logic     req_valid;
    logic     req_ready;
    pe_resp_t resp;
    pe_req_t  vinsn;
    logic     vinsn_valid;
    logic     hz_free;
    logic     commit;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pe_vinsn_queue dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .pe_req_i           (req),
        .pe_req_valid_i     (req_valid),
        .pe_req_ready_o     (req_ready),
        .pe_resp_o          (resp),
        .vinsn_o            (vinsn),
        .vinsn_valid_o      (vinsn_valid),
        .vinsn_hazard_free_o(hz_free),
        .vinsn_commit_i     (commit)
    );

    // Reference model: an in-order list of accepted instructions.
    typedef struct {
        logic [2:0] id;
        vfu_e       vfu;
        logic [7:0] op;
        logic [7:0] v1, v2, vd, vm;
    } ment_t;

    ment_t      mq[$];
    bit         m_flag;
    logic [2:0] m_id;
    logic [7:0] m_done;

    task automatic step();
        ment_t      e;
        bit         full, acc, push, pop;
        logic [7:0] done_n;
        if (!rst_n) begin
            mq.delete();
            m_flag = 0;
            m_done = 8'h00;
        end else begin
            full   = (mq.size() == DEPTH);
            pop    = commit && (mq.size() != 0);
            done_n = pop ? (8'h01 << mq[0].id) : 8'h00;
            acc    = req_valid && !full && !(m_flag && m_id == req.id);
            push   = acc && (int'(req.vfu) < 2);
            foreach (mq[i]) begin
                mq[i].v1 = mq[i].v1 & req.vinsn_running;
                mq[i].v2 = mq[i].v2 & req.vinsn_running;
                mq[i].vd = mq[i].vd & req.vinsn_running;
                mq[i].vm = mq[i].vm & req.vinsn_running;
            end
            if (pop) void'(mq.pop_front());
            if (push) begin
                e.id  = req.id;
                e.vfu = req.vfu;
                e.op  = req.op;
                e.v1  = req.hazard_vs1 & req.vinsn_running;
                e.v2  = req.hazard_vs2 & req.vinsn_running;
                e.vd  = req.hazard_vd & req.vinsn_running;
                e.vm  = req.hazard_vm & req.vinsn_running;
                mq.push_back(e);
            end
            if (!req_valid) m_flag = 0;
            else if (acc) begin
                m_flag = 1;
                m_id   = req.id;
            end
            m_done = done_n;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] id, input vfu_e vfu, input logic [7:0] vs1,
                           input logic [7:0] running);
        req               = '0;
        req.id            = id;
        req.vfu           = vfu;
        req.op            = 8'($urandom);
        req.hazard_vs1    = vs1;
        req.vinsn_running = running;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        commit    = 1'b0;
        req       = '0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", req_ready); end
        checks++; if (vinsn_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", vinsn_valid); end
        checks++; if (vinsn !== pe_req_t'('0)) begin failures++; $display("FAIL reset_vinsn got=%0h exp=0", vinsn); end
        checks++; if (hz_free !== 1'b1) begin failures++; $display("FAIL reset_hazard_free got=%0b exp=1", hz_free); end
        checks++; if (resp !== pe_resp_t'('0)) begin failures++; $display("FAIL reset_resp got=%0h exp=0", resp); end
    endtask

    task automatic test_basic_accept();
        do_reset();
        set_req(3'd3, VFU_Alu, 8'h00, 8'h00);
        req_valid = 1'b1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_pre got=%0b exp=1", req_ready); end
        step();
        req_valid = 1'b0;
        checks++; if (vinsn_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0b exp=1", vinsn_valid); end
        checks++; if (vinsn.id !== 3'd3) begin failures++; $display("FAIL basic_id got=%0d exp=3", vinsn.id); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_post got=%0b exp=1", req_ready); end
        commit = 1'b1;
        step();
        commit = 1'b0;
        checks++; if (resp.vinsn_done !== 8'b0000_1000) begin failures++; $display("FAIL basic_done got=%0h exp=08", resp.vinsn_done); end
        checks++; if (vinsn_valid !== 1'b0) begin failures++; $display("FAIL basic_empty got=%0b exp=0", vinsn_valid); end
        step();
        checks++; if (resp.vinsn_done !== 8'h00) begin failures++; $display("FAIL basic_done_clear got=%0h exp=00", resp.vinsn_done); end
    endtask

    task automatic test_held_request();
        do_reset();
        set_req(3'd2, VFU_MFpu, 8'h00, 8'h00);
        req_valid = 1'b1;
        repeat (4) step();
        checks++; if (dut.cnt !== 3'd1) begin failures++; $display("FAIL held_cnt got=%0d exp=1", dut.cnt); end
        set_req(3'd5, VFU_Alu, 8'h00, 8'h00);
        step();
        req_valid = 1'b0;
        checks++; if (dut.cnt !== 3'd2) begin failures++; $display("FAIL held_second_cnt got=%0d exp=2", dut.cnt); end
        checks++; if (vinsn.id !== 3'd2) begin failures++; $display("FAIL held_head got=%0d exp=2", vinsn.id); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(3'(i), VFU_Alu, 8'h00, 8'h00);
            step();
        end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%0b exp=0", req_ready); end
        set_req(3'd4, VFU_Alu, 8'h00, 8'h00);
        repeat (2) step();
        checks++; if (dut.cnt !== 3'd4) begin failures++; $display("FAIL full_blocked_cnt got=%0d exp=4", dut.cnt); end
        commit = 1'b1;
        step();
        commit = 1'b0;
        checks++; if (resp.vinsn_done !== 8'h01) begin failures++; $display("FAIL full_done0 got=%0h exp=01", resp.vinsn_done); end
        checks++; if (dut.cnt !== 3'd3) begin failures++; $display("FAIL full_no_popthrough got=%0d exp=3", dut.cnt); end
        step();
        checks++; if (dut.cnt !== 3'd4) begin failures++; $display("FAIL full_id4_pushed got=%0d exp=4", dut.cnt); end
        req_valid = 1'b0;
        commit    = 1'b1;
        step();
        checks++; if (resp.vinsn_done !== 8'h02) begin failures++; $display("FAIL full_done1 got=%0h exp=02", resp.vinsn_done); end
        for (int k = 0; k < 10; k++) begin
            req_valid = 1'b1;
            set_req(3'((5 + k) % 8), VFU_Alu, 8'h00, 8'h00);
            step();
            checks++;
            if (resp.vinsn_done !== (8'h01 << ((2 + k) % 8))) begin
                failures++;
                $display("FAIL wrap_order k=%0d got=%0h exp=%0h", k, resp.vinsn_done, 8'h01 << ((2 + k) % 8));
            end
        end
        req_valid = 1'b0;
        commit    = 1'b0;
        checks++; if (dut.cnt !== 3'd3) begin failures++; $display("FAIL wrap_cnt got=%0d exp=3", dut.cnt); end
    endtask

    task automatic test_irrelevant();
        do_reset();
        set_req(3'd1, VFU_LoadUnit, 8'h00, 8'h00);
        req_valid = 1'b1;
        repeat (2) step();
        req_valid = 1'b0;
        checks++; if (vinsn_valid !== 1'b0) begin failures++; $display("FAIL irrel_pushed got=%0b exp=0", vinsn_valid); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL irrel_ready got=%0b exp=1", req_ready); end
        step();
    endtask

    task automatic test_hazard();
        do_reset();
        set_req(3'd6, VFU_Alu, 8'h06, 8'h06);
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        req.vinsn_running = 8'h04;
        checks++; if (vinsn.hazard_vs1 !== 8'h06) begin failures++; $display("FAIL hz_initial got=%0h exp=06", vinsn.hazard_vs1); end
        step();
        checks++; if (vinsn.hazard_vs1 !== 8'h04) begin failures++; $display("FAIL hz_masked got=%0h exp=04", vinsn.hazard_vs1); end
        checks++; if (hz_free !== 1'b0) begin failures++; $display("FAIL hz_busy got=%0b exp=0", hz_free); end
        req.vinsn_running = 8'h00;
        step();
        checks++; if (hz_free !== 1'b1) begin failures++; $display("FAIL hz_free got=%0b exp=1", hz_free); end
    endtask

    task automatic test_simultaneous_and_reset();
        do_reset();
        set_req(3'd2, VFU_Alu, 8'h00, 8'h00);
        req_valid = 1'b1;
        step();
        set_req(3'd7, VFU_Alu, 8'h00, 8'h00);
        commit = 1'b1;
        step();
        req_valid = 1'b0;
        commit    = 1'b0;
        checks++; if (dut.cnt !== 3'd1) begin failures++; $display("FAIL simul_cnt got=%0d exp=1", dut.cnt); end
        checks++; if (vinsn.id !== 3'd7) begin failures++; $display("FAIL simul_head got=%0d exp=7", vinsn.id); end
        checks++; if (resp.vinsn_done !== 8'h04) begin failures++; $display("FAIL simul_done got=%0h exp=04", resp.vinsn_done); end
        commit = 1'b1;
        step();
        commit    = 1'b0;
        req_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            set_req(3'(i), VFU_MFpu, 8'hff, 8'hff);
            step();
        end
        req_valid = 1'b0;
        commit    = 1'b1;
        rst_n     = 1'b0;
        step();
        rst_n = 1'b1;
        commit = 1'b0;
        checks++; if (vinsn_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%0b exp=0", vinsn_valid); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got=%0b exp=1", req_ready); end
        checks++; if (hz_free !== 1'b1) begin failures++; $display("FAIL rst_mid_hz got=%0b exp=1", hz_free); end
        checks++; if (resp !== pe_resp_t'('0)) begin failures++; $display("FAIL rst_mid_done got=%0h exp=0", resp); end
        step();
        checks++; if (resp !== pe_resp_t'('0)) begin failures++; $display("FAIL rst_mid_done_late got=%0h exp=0", resp); end
    endtask

    task automatic test_random();
        logic [2:0] last_id = 3'd0;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            req_valid = ($urandom_range(0, 9) < 7);
            commit    = ($urandom_range(0, 9) < 4);
            req       = pe_req_t'({$urandom, $urandom});
            req.vfu   = vfu_e'($urandom_range(0, 3) == 0 ? $urandom_range(2, 6) : $urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) req.id = last_id;
            req.vinsn_running = ($urandom_range(0, 3) == 0) ? 8'hff : 8'($urandom);
            last_id = req.id;
            step();
            checks++; if (req_ready !== (mq.size() < DEPTH)) begin failures++; $display("FAIL rnd_ready n=%0d got=%0b exp=%0b", n, req_ready, mq.size() < DEPTH); end
            checks++; if (vinsn_valid !== (mq.size() != 0)) begin failures++; $display("FAIL rnd_valid n=%0d got=%0b exp=%0b", n, vinsn_valid, mq.size() != 0); end
            checks++; if (resp.vinsn_done !== m_done) begin failures++; $display("FAIL rnd_done n=%0d got=%0h exp=%0h", n, resp.vinsn_done, m_done); end
            if (mq.size() != 0) begin
                checks++;
                if ({vinsn.id, vinsn.vfu, vinsn.op, vinsn.hazard_vs1, vinsn.hazard_vs2, vinsn.hazard_vd, vinsn.hazard_vm}
                    !== {mq[0].id, mq[0].vfu, mq[0].op, mq[0].v1, mq[0].v2, mq[0].vd, mq[0].vm}) begin
                    failures++;
                    $display("FAIL rnd_head n=%0d got_id=%0d exp_id=%0d got_vs1=%0h exp_vs1=%0h got_vd=%0h exp_vd=%0h",
                             n, vinsn.id, mq[0].id, vinsn.hazard_vs1, mq[0].v1, vinsn.hazard_vd, mq[0].vd);
                end
                checks++;
                if (hz_free !== ((mq[0].v1 | mq[0].v2 | mq[0].vd | mq[0].vm) == 8'h00)) begin
                    failures++;
                    $display("FAIL rnd_hazard_free n=%0d got=%0b", n, hz_free);
                end
            end else begin
                checks++; if (vinsn !== pe_req_t'('0)) begin failures++; $display("FAIL rnd_empty_vinsn n=%0d got=%0h exp=0", n, vinsn); end
            end
        end
        rst_n     = 1'b1;
        req_valid = 1'b0;
        commit    = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        commit    = 1'b0;
        req       = '0;
        test_reset();
        test_basic_accept();
        test_held_request();
        test_full_wrap();
        test_irrelevant();
        test_hazard();
        test_simultaneous_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
